// File: rtl/csr_unit_pkg.sv
// Shared definitions for the CSR unit: core FSM state codes used to time
// CSR accesses, CSR addresses, CSR operation encodings and address decode
// helpers used by the optional illegal-access trap (CSR_ILLEGAL_TRAP_EN).
package csr_unit_pkg;

    // Core FSM states in which the CSR unit reads and writes
    localparam logic [2:0] REG_FILE_READ = 3'd2;
    localparam logic [2:0] WRITE_BACK    = 3'd4;

    // CSR address map
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;

    // Zicsr read-modify-write operations
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // True for the user-mode counter views that software may only read
    function automatic logic csr_is_read_only(input logic [11:0] adr);
        case (adr)
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // True for every address the unit implements
    function automatic logic csr_is_mapped(input logic [11:0] adr);
        case (adr)
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MCOUNTINHIBIT, CSR_MSCRATCH:                  return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Core-to-CSR-unit connection. The core side (master) presents the decoded
// CSR instruction each cycle; the CSR unit (slave) returns the old CSR value
// and, when CSR_ILLEGAL_TRAP_EN is defined, the illegal-access flag.
interface csr_unit_if;

    logic [2:0]  state_i;
    logic        en_csr_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_wdata_i;
    logic        instr_retired_i;
    logic [31:0] csr_val_o;
`ifdef CSR_ILLEGAL_TRAP_EN
    logic        illegal_o;

    modport master (
        output state_i, en_csr_i, csr_op_i, csr_adr_i, csr_wdata_i, instr_retired_i,
        input  csr_val_o, illegal_o
    );

    modport slave (
        input  state_i, en_csr_i, csr_op_i, csr_adr_i, csr_wdata_i, instr_retired_i,
        output csr_val_o, illegal_o
    );
`else
    modport master (
        output state_i, en_csr_i, csr_op_i, csr_adr_i, csr_wdata_i, instr_retired_i,
        input  csr_val_o
    );

    modport slave (
        input  state_i, en_csr_i, csr_op_i, csr_adr_i, csr_wdata_i, instr_retired_i,
        output csr_val_o
    );
`endif

endinterface

// File: rtl/csr_counter.sv
// W-bit event counter built from a 32-bit low half and an optional upper
// half. The low-half wrap is held in a registered carry that the upper half
// absorbs on the next enabled increment, keeping the adder chain 32 bits
// long. A half write replaces only that half and beats its own increment.
// The value is zero-extended to 64 bits.
module csr_counter #(
    parameter int W = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [31:0] r_lo;

    // Low half: a write replaces it, otherwise it counts when enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lo <= '0;
        end else if (i_wr_lo) begin
            r_lo <= i_wdata;
        end else if (i_inc) begin
            r_lo <= r_lo + 32'd1;
        end
    end

    generate
        if (W > 32) begin : g_hi
            localparam int HW = W - 32;

            logic [HW-1:0] r_hi;
            logic          r_carry;

            // Carry is consumed on every enabled increment; a low-half write
            // cancels the wrap that would otherwise have been generated
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_carry <= 1'b0;
                end else if (i_inc) begin
                    r_carry <= !i_wr_lo && (r_lo == '1);
                end
            end

            // Upper half: a write wins, otherwise it absorbs the pending carry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_hi <= '0;
                end else if (i_wr_hi) begin
                    r_hi <= i_wdata[HW-1:0];
                end else if (i_inc && r_carry) begin
                    r_hi <= r_hi + HW'(1);
                end
            end

            assign o_value = 64'({r_hi, r_lo});
        end else begin : g_no_hi
            logic w_unused_wr_hi;

            assign w_unused_wr_hi = i_wr_hi;
            assign o_value        = 64'(r_lo);
        end
    endgenerate

endmodule

// File: rtl/csr_unit.sv
// CSR unit beside the register file: cycle/instret counters with machine
// write aliases, mcountinhibit and mscratch. The old CSR value is latched
// in REG_FILE_READ and the read-modify-write result is committed in
// WRITE_BACK. Optional feature macro: CSR_ILLEGAL_TRAP_EN adds illegal_o
// and suppresses the write phase of an illegal access.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter bit SCRATCH_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    csr_unit_if.slave  bus
);

    csr_op_e     w_op;
    logic        w_read_en;
    logic        w_write_req;
    logic        w_write_en;
    logic        w_illegal_block;
    logic [31:0] w_rdata;
    logic [31:0] w_new_val;
    logic [31:0] w_mscratch;
    logic [63:0] w_cycle;
    logic [63:0] w_instret;
    logic        w_cyc_wr_lo;
    logic        w_cyc_wr_hi;
    logic        w_ins_wr_lo;
    logic        w_ins_wr_hi;
    logic        r_cy;
    logic        r_ir;
    logic [31:0] r_csr_val;

    assign w_op      = csr_op_e'(bus.csr_op_i);
    assign w_read_en = bus.en_csr_i && (bus.state_i == REG_FILE_READ);

    // Set/clear with a zero mask is a pure read and never writes
    assign w_write_req = bus.en_csr_i && (bus.state_i == WRITE_BACK) && (w_op != CSR_OP_NONE)
                         && !(((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && (bus.csr_wdata_i == '0));

`ifdef CSR_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Illegal flag is re-evaluated at every read edge and blocks that instruction's write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal <= 1'b0;
        end else if (w_read_en) begin
            r_illegal <= !csr_is_mapped(bus.csr_adr_i)
                         || (csr_is_read_only(bus.csr_adr_i)
                             && ((w_op == CSR_OP_RW)
                                 || (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC))
                                     && (bus.csr_wdata_i != '0))));
        end
    end

    assign w_illegal_block = r_illegal;
    assign bus.illegal_o   = r_illegal;
`else
    assign w_illegal_block = 1'b0;
`endif

    assign w_write_en = w_write_req && !w_illegal_block;

    // Read-modify-write result, always based on the value latched at the read edge
    always_comb begin
        w_new_val = bus.csr_wdata_i;
        case (w_op)
            CSR_OP_RS: w_new_val = r_csr_val | bus.csr_wdata_i;
            CSR_OP_RC: w_new_val = r_csr_val & ~bus.csr_wdata_i;
            default:   w_new_val = bus.csr_wdata_i;
        endcase
    end

    // Read mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = '0;
        case (bus.csr_adr_i)
            CSR_CYCLE,    CSR_MCYCLE:    w_rdata = w_cycle[31:0];
            CSR_CYCLEH,   CSR_MCYCLEH:   w_rdata = w_cycle[63:32];
            CSR_INSTRET,  CSR_MINSTRET:  w_rdata = w_instret[31:0];
            CSR_INSTRETH, CSR_MINSTRETH: w_rdata = w_instret[63:32];
            CSR_MCOUNTINHIBIT:           w_rdata = {29'd0, r_ir, 1'b0, r_cy};
            CSR_MSCRATCH:                w_rdata = w_mscratch;
            default:                     w_rdata = '0;
        endcase
    end

    // Only the machine aliases are writable; user views fall through and are dropped
    assign w_cyc_wr_lo = w_write_en && (bus.csr_adr_i == CSR_MCYCLE);
    assign w_cyc_wr_hi = w_write_en && (bus.csr_adr_i == CSR_MCYCLEH);
    assign w_ins_wr_lo = w_write_en && (bus.csr_adr_i == CSR_MINSTRET);
    assign w_ins_wr_hi = w_write_en && (bus.csr_adr_i == CSR_MINSTRETH);

    // Old CSR value latch, held until the next CSR read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_csr_val <= '0;
        end else if (w_read_en) begin
            r_csr_val <= w_rdata;
        end
    end

    assign bus.csr_val_o = r_csr_val;

    // Counter inhibit bits; being registered they gate counting from the following cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cy <= 1'b0;
            r_ir <= 1'b0;
        end else if (w_write_en && (bus.csr_adr_i == CSR_MCOUNTINHIBIT)) begin
            r_cy <= w_new_val[0];
            r_ir <= w_new_val[2];
        end
    end

    generate
        if (SCRATCH_EN) begin : g_scratch
            logic [31:0] r_mscratch;

            // Scratch register for machine-mode software
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_mscratch <= '0;
                end else if (w_write_en && (bus.csr_adr_i == CSR_MSCRATCH)) begin
                    r_mscratch <= w_new_val;
                end
            end

            assign w_mscratch = r_mscratch;
        end else begin : g_no_scratch
            assign w_mscratch = '0;
        end
    endgenerate

    csr_counter #(.W(CNT_W)) u_cycle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (!r_cy),
        .i_wr_lo (w_cyc_wr_lo),
        .i_wr_hi (w_cyc_wr_hi),
        .i_wdata (w_new_val),
        .o_value (w_cycle)
    );

    csr_counter #(.W(CNT_W)) u_instret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (bus.instr_retired_i && !r_ir),
        .i_wr_lo (w_ins_wr_lo),
        .i_wr_hi (w_ins_wr_hi),
        .i_wdata (w_new_val),
        .o_value (w_instret)
    );

endmodule
